// File: rtl/parking_time_log.sv
// Eight-slot parking log: allocates slots on entry, reports entry/exit time pairs on exit.
// Optional per-slot overstay flags are compiled in when OVERSTAY_EN is defined.
module parking_time_log (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       car_in,
  input  logic       car_out,
  input  logic [2:0] out_slot_req,
  output logic [2:0] in_slot,
  output logic       in_ack,
  output logic [7:0] time_in,
  output logic [7:0] time_out,
  output logic [2:0] out_slot,
  output logic       out_valid,
  output logic [3:0] free_count,
  output logic       full,
  output logic       err,
  output logic [7:0] overstay
);

  logic [7:0] now;
  logic [7:0] occ;
  logic [7:0] entry [8];

  logic       exit_ok;
  logic       entry_ok;
  logic       reject;
  logic       free_any;
  logic [2:0] alloc_idx;
  logic [7:0] occ_mid;
  logic [7:0] occ_nxt;
  logic [3:0] free_nxt;

  // Exit is resolved first so a full lot can hand the freed slot to a same-cycle entry.
  always_comb begin
    exit_ok = car_out & occ[out_slot_req];
    occ_mid = occ;
    if (exit_ok) occ_mid[out_slot_req] = 1'b0;

    free_any  = |(~occ_mid);
    alloc_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ_mid[i]) alloc_idx = 3'(i);
    end

    entry_ok = car_in & free_any;
    occ_nxt  = occ_mid;
    if (entry_ok) occ_nxt[alloc_idx] = 1'b1;

    reject = (car_in & ~free_any) | (car_out & ~occ[out_slot_req]);

    free_nxt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      free_nxt = free_nxt + {3'd0, ~occ_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      now        <= 8'd0;
      occ        <= 8'd0;
      for (int i = 0; i < 8; i++) entry[i] <= 8'd0;
      in_slot    <= 3'd0;
      in_ack     <= 1'b0;
      time_in    <= 8'd0;
      time_out   <= 8'd0;
      out_slot   <= 3'd0;
      out_valid  <= 1'b0;
      free_count <= 4'd8;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Requests see the pre-increment time base when coinciding with tick.
      if (tick) now <= now + 8'd1;
      occ        <= occ_nxt;
      in_ack     <= entry_ok;
      out_valid  <= exit_ok;
      err        <= reject;
      free_count <= free_nxt;
      full       <= (free_nxt == 4'd0);
      if (entry_ok) begin
        entry[alloc_idx] <= now;
        in_slot          <= alloc_idx;
      end
      if (exit_ok) begin
        time_in  <= entry[out_slot_req];
        time_out <= now;
        out_slot <= out_slot_req;
      end
    end
  end

`ifdef OVERSTAY_EN
  // A flag clears whenever its slot is released or handed to a new car in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overstay <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if ((exit_ok && out_slot_req == 3'(i)) || (entry_ok && alloc_idx == 3'(i)))
          overstay[i] <= 1'b0;
        else if (occ[i] && ((now - entry[i]) == 8'd255))
          overstay[i] <= 1'b1;
      end
    end
  end
`else
  assign overstay = 8'd0;
`endif

endmodule

// File: tb/tb_parking_time_log.sv
// Directed bench for parking_time_log; overstay expectations follow OVERSTAY_EN.
module tb_parking_time_log;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       car_in;
  logic       car_out;
  logic [2:0] out_slot_req;
  logic [2:0] in_slot;
  logic       in_ack;
  logic [7:0] time_in;
  logic [7:0] time_out;
  logic [2:0] out_slot;
  logic       out_valid;
  logic [3:0] free_count;
  logic       full;
  logic       err;
  logic [7:0] overstay;

  int n_checks = 0;
  int n_pass   = 0;

  parking_time_log dut (
    .clk(clk), .reset(reset), .tick(tick), .car_in(car_in), .car_out(car_out),
    .out_slot_req(out_slot_req), .in_slot(in_slot), .in_ack(in_ack),
    .time_in(time_in), .time_out(time_out), .out_slot(out_slot),
    .out_valid(out_valid), .free_count(free_count), .full(full), .err(err),
    .overstay(overstay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock cycle with the given request inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic t, input logic ci, input logic co, input logic [2:0] s);
    tick = t; car_in = ci; car_out = co; out_slot_req = s;
    @(posedge clk);
    #1;
    tick = 1'b0; car_in = 1'b0; car_out = 1'b0; out_slot_req = 3'd0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  logic [7:0] ovs_exp;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; car_in = 1'b0; car_out = 1'b0; out_slot_req = 3'd0;
    #3;
    check("rst_free", free_count, 8);
    check("rst_full", full, 0);
    check("rst_ack", in_ack, 0);
    check("rst_vld", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_ovs", overstay, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic entry/exit with 3 and 12 ticks.
    ticks(3);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("in_ack", in_ack, 1);
    check("in_slot", in_slot, 0);
    check("free7", free_count, 7);
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
    check("in_ack_drop", in_ack, 0);
    check("in_slot_hold", in_slot, 0);
    ticks(12);
    cyc(1'b0, 1'b0, 1'b1, 3'd0);
    check("out_valid", out_valid, 1);
    check("time_in3", time_in, 3);
    check("time_out15", time_out, 15);
    check("out_slot0", out_slot, 0);
    check("free8", free_count, 8);
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
    check("out_valid_drop", out_valid, 0);
    check("time_in_hold", time_in, 3);
    check("time_out_hold", time_out, 15);

    // Fill all eight slots, then overflow.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 3'd0);
      check("fill_slot", in_slot, i);
      check("fill_ack", in_ack, 1);
    end
    check("full_set", full, 1);
    check("free0", free_count, 0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("ovf_err", err, 1);
    check("ovf_ack", in_ack, 0);
    check("ovf_free", free_count, 0);
    check("ovf_slot_hold", in_slot, 7);

    // Simultaneous exit of slot 2 and entry on a full lot.
    cyc(1'b0, 1'b1, 1'b1, 3'd2);
    check("both_vld", out_valid, 1);
    check("both_oslot", out_slot, 2);
    check("both_tin", time_in, 15);
    check("both_ack", in_ack, 1);
    check("both_islot", in_slot, 2);
    check("both_full", full, 1);
    check("both_err", err, 0);

    // Empty the lot.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 3'(i));
      check("drain_vld", out_valid, 1);
    end
    check("drain_free", free_count, 8);
    check("drain_full", full, 0);

    // Exit from an empty slot is rejected.
    cyc(1'b0, 1'b0, 1'b1, 3'd5);
    check("empty_err", err, 1);
    check("empty_vld", out_valid, 0);
    check("empty_free", free_count, 8);
    check("empty_oslot_hold", out_slot, 7);
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
    check("err_drop", err, 0);

    // Wrap: entry at 250, exit 20 ticks later at 14.
    ticks(235);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("wrap_slot", in_slot, 0);
    ticks(20);
    cyc(1'b0, 1'b0, 1'b1, 3'd0);
    check("wrap_tin", time_in, 250);
    check("wrap_tout", time_out, 14);

    // Tick coinciding with requests uses the pre-increment time.
    cyc(1'b1, 1'b1, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 1'b1, 3'd0);
    check("tick_tin", time_in, 14);
    check("tick_tout", time_out, 15);

    // Overstay: entry at now=0, 255 ticks.
    ticks(240);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("ovs_slot", in_slot, 0);
    ticks(255);
    check("ovs_early", overstay, 0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
`ifdef OVERSTAY_EN
    ovs_exp = 8'h01;
`else
    ovs_exp = 8'h00;
`endif
    check("ovs_set", overstay, ovs_exp);
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
    check("ovs_hold", overstay, ovs_exp);
    cyc(1'b0, 1'b0, 1'b1, 3'd0);
    check("ovs_exit_tin", time_in, 0);
    check("ovs_exit_tout", time_out, 255);
    check("ovs_clear", overstay, 0);

    // Reset in the middle of an in_ack pulse.
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("mid_ack", in_ack, 1);
    check("mid_slot", in_slot, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", in_ack, 0);
    check("mid_rst_slot", in_slot, 0);
    check("mid_rst_free", free_count, 8);
    check("mid_rst_tout", time_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'd0);
    check("post_rst_ack", in_ack, 0);
    check("post_rst_vld", out_valid, 0);
    ticks(2);
    cyc(1'b0, 1'b1, 1'b0, 3'd0);
    check("post_rst_slot", in_slot, 0);
    check("post_rst_free", free_count, 7);
    cyc(1'b0, 1'b0, 1'b1, 3'd0);
    check("post_rst_tin", time_in, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_time_log.md
PARKING_TIME_LOG -- requirements
Module: parking_time_log

Interface
REQ-001 SHALL have port clk, input, 1, single clock, rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port tick, input, 1, one-cycle pulse, advances the time base by one unit.
REQ-004 SHALL have port car_in, input, 1, one-cycle entry request; the block allocates a slot.
REQ-005 SHALL have port car_out, input, 1, one-cycle exit request for out_slot_req.
REQ-006 SHALL have port out_slot_req, input, 3, slot index of the exiting car.
REQ-007 SHALL have port in_slot, output, 3, slot allocated to the last accepted entry.
REQ-008 SHALL have port in_ack, output, 1, one-cycle pulse when an entry is accepted.
REQ-009 SHALL have port time_in, output, 8, stored entry time of the exiting car; feeds the downstream time_in.
REQ-010 SHALL have port time_out, output, 8, time base value at exit; feeds the downstream time_out.
REQ-011 SHALL have port out_slot, output, 3, slot released by the exit.
REQ-012 SHALL have port out_valid, output, 1, one-cycle pulse qualifying time_in, time_out and out_slot.
REQ-013 SHALL have port free_count, output, 4, number of free slots, 0 to 8.
REQ-014 SHALL have port full, output, 1, high when free_count is 0.
REQ-015 SHALL have port err, output, 1, one-cycle pulse when a request is rejected.
REQ-016 SHALL have port overstay, output, 8, per-slot overstay flags.

Function
REQ-017 SHALL hold an 8-bit time base now that increments on each tick and wraps from 255 to 0.
REQ-018 SHALL keep 8 slots, each holding an occupied bit and an 8-bit entry time.
REQ-019 SHALL, on an accepted car_in, allocate the lowest-index free slot, store now as its entry time, and set it occupied.
REQ-020 SHALL, on an accepted car_in, drive in_slot and pulse in_ack in the following cycle (1-cycle latency).
REQ-021 SHALL, on an accepted car_out, output that slot's entry time on time_in and now on time_out, pulse out_valid in the following cycle, and clear the slot.
REQ-022 SHALL, when tick and a request arrive in the same cycle, use the value of now before the increment.
REQ-023 SHALL reject car_in when full: pulse err, change no state.
REQ-024 SHALL reject car_out on an unoccupied slot: pulse err, no out_valid, change no state.
REQ-025 SHALL, when car_in and car_out are asserted together, process the exit first, then the entry in the same cycle, so a full lot accepts both and the entry may reuse the freed slot.
REQ-026 SHALL let time_out be smaller than time_in after a wrap; the downstream stage subtracts modulo 256, which is correct for stays under 256 ticks.
REQ-027 SHALL hold time_in, time_out, out_slot and in_slot at their last values while out_valid or in_ack is low.
REQ-028 SHALL update free_count and full registered, in the cycle after each accepted request.

Reset
REQ-029 SHALL, on reset assertion, immediately clear now, all occupied bits, all entry times, all outputs and overstay, set free_count to 8, and leave full low.
REQ-030 SHALL, if reset asserts mid-operation, drop any pending out_valid, in_ack or err pulse; no partial transaction is emitted after reset release.

Configuration
REQ-031 SHALL, with OVERSTAY_EN defined, set overstay[i] when slot i is occupied and (now - entry_i) mod 256 equals 255, holding it set until the slot is released or reset asserts.
REQ-032 SHALL, without OVERSTAY_EN, drive overstay constant 0 and contain no overstay comparators.

Verification
REQ-033 SHALL cover: reset, 3 ticks, car_in -> in_ack with in_slot=0, free_count=7; 12 more ticks, car_out slot 0 -> out_valid with time_in=3, time_out=15.
REQ-034 SHALL cover: 8 car_in -> in_slot values 0..7, full=1; 9th car_in -> err=1, free_count stays 0.
REQ-035 SHALL cover: car_out on empty slot 5 -> err=1, out_valid=0, free_count unchanged.
REQ-036 SHALL cover: entry at now=250, 20 ticks, exit -> time_in=250, time_out=14.
REQ-037 SHALL cover: full lot, car_in and car_out for slot 2 together -> out_valid, in_ack with in_slot=2, full stays 1.
REQ-038 SHALL cover, with OVERSTAY_EN: entry at now=0, 255 ticks -> overstay[0]=1, cleared by exit; without the macro, overstay stays 0.
